// File: rtl/weight_loader_pkg.sv
// Shared definitions for the PE weight path: loader state encoding and
// default word/address widths.
package weight_loader_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_GAP    = 2'd2,
    ST_FINISH = 2'd3
  } wl_state_t;

endpackage

// File: rtl/weight_loader.sv
// Streams weight words from a valid/ready source into the PE weight port,
// one registered write per accepted word, with optional idle gaps.
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int WR_GAP     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] num_words,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] weight_wr_data,
  output logic [ADDR_WIDTH-1:0] weight_wr_addr,
  output logic                  weight_wr_en,
  output logic                  busy,
  output logic                  done
);

  localparam int GAP_W = (WR_GAP > 0) ? $clog2(WR_GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = (WR_GAP > 0) ? GAP_W'(WR_GAP - 1) : '0;
  localparam bit HAS_GAP = (WR_GAP > 0);

  wl_state_t             state;
  wl_state_t             state_next;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] num_q;
  logic [ADDR_WIDTH-1:0] idx;
  logic [GAP_W-1:0]      gap_cnt;
  logic                  accept;
  logic                  last_word;

  // Abort wins over a same-cycle accept, so the dropped word never reaches the port.
  assign accept    = (state == ST_LOAD) && s_valid && !abort;
  assign last_word = (idx == (num_q - {{(ADDR_WIDTH-1){1'b0}}, 1'b1}));

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = (num_words == '0) ? ST_FINISH : ST_LOAD;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (accept) begin
          if (last_word) begin
            state_next = ST_FINISH;
          end else if (HAS_GAP) begin
            state_next = ST_GAP;
          end else begin
            state_next = ST_LOAD;
          end
        end else begin
          state_next = ST_LOAD;
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (gap_cnt == GAP_LAST) begin
          state_next = ST_LOAD;
        end else begin
          state_next = ST_GAP;
        end
      end
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // State register and status outputs derived from it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      s_ready <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      s_ready <= (state_next == ST_LOAD);
      busy    <= (state_next != ST_IDLE);
      done    <= (state == ST_FINISH);
    end
  end

  // Load descriptor capture and word index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      num_q  <= '0;
      idx    <= '0;
    end else if ((state == ST_IDLE) && start) begin
      base_q <= base_addr;
      num_q  <= num_words;
      idx    <= '0;
    end else if (accept) begin
      idx    <= idx + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Gap counter, cleared whenever the FSM leaves GAP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt <= '0;
    end else if ((state == ST_GAP) && (state_next == ST_GAP)) begin
      gap_cnt <= gap_cnt + {{(GAP_W-1){1'b0}}, 1'b1};
    end else begin
      gap_cnt <= '0;
    end
  end

  // Weight port: strobe one cycle after each accept, address/data hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight_wr_en   <= 1'b0;
      weight_wr_addr <= '0;
      weight_wr_data <= '0;
    end else begin
      weight_wr_en <= accept;
      if (accept) begin
        weight_wr_addr <= base_q + idx;
        weight_wr_data <= s_data;
      end
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: one instance with WR_GAP=0 (g0) and one
// with WR_GAP=2 (g2) share the stream inputs; each has its own start.
module tb_weight_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0, start2, abort, s_valid;
  logic [31:0] base_addr, num_words;
  logic [15:0] s_data;

  logic        s_ready0, wr_en0, busy0, done0;
  logic [31:0] wr_addr0;
  logic [15:0] wr_data0;
  logic        s_ready2, wr_en2, busy2, done2;
  logic [31:0] wr_addr2;
  logic [15:0] wr_data2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [47:0] q0[$];
  logic [47:0] q2[$];

  always #5 clk = ~clk;

  weight_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(32), .WR_GAP(0)) g0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .base_addr(base_addr),
    .num_words(num_words), .abort(abort), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready0), .weight_wr_data(wr_data0), .weight_wr_addr(wr_addr0),
    .weight_wr_en(wr_en0), .busy(busy0), .done(done0)
  );

  weight_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(32), .WR_GAP(2)) g2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .base_addr(base_addr),
    .num_words(num_words), .abort(abort), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready2), .weight_wr_data(wr_data2), .weight_wr_addr(wr_addr2),
    .weight_wr_en(wr_en2), .busy(busy2), .done(done2)
  );

  // Pop expected writes as each instance strobes its weight port
  always @(negedge clk) begin
    logic [47:0] e;
    if (rst_n && wr_en0) begin
      n_checks++;
      if (q0.size() == 0) begin
        n_fail++;
        $display("FAIL g0_unexpected_write: got addr=%h data=%h, expected no write", wr_addr0, wr_data0);
      end else begin
        e = q0.pop_front();
        if ({wr_addr0, wr_data0} !== e) begin
          n_fail++;
          $display("FAIL g0_write: got addr=%h data=%h, expected addr=%h data=%h",
                   wr_addr0, wr_data0, e[47:16], e[15:0]);
        end
      end
    end
    if (rst_n && wr_en2) begin
      n_checks++;
      if (q2.size() == 0) begin
        n_fail++;
        $display("FAIL g2_unexpected_write: got addr=%h data=%h, expected no write", wr_addr2, wr_data2);
      end else begin
        e = q2.pop_front();
        if ({wr_addr2, wr_data2} !== e) begin
          n_fail++;
          $display("FAIL g2_write: got addr=%h data=%h, expected addr=%h data=%h",
                   wr_addr2, wr_data2, e[47:16], e[15:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start0 = 1'b0; start2 = 1'b0; abort = 1'b0; s_valid = 1'b0;
    base_addr = 32'd0; num_words = 32'd0; s_data = 16'd0;
    #12;
    n_checks++;
    if ({s_ready0, wr_en0, busy0, done0, wr_addr0, wr_data0,
         s_ready2, wr_en2, busy2, done2, wr_addr2, wr_data2} !== 104'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got g0 r/w/b/d=%b%b%b%b g2 r/w/b/d=%b%b%b%b, expected all 0",
               s_ready0, wr_en0, busy0, done0, s_ready2, wr_en2, busy2, done2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] a;
    base_addr = 32'd23; num_words = 32'd4; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({s_ready0, wr_en0} !== {1'b1, (i > 0)}) begin
        n_fail++;
        $display("FAIL basic_stream c%0d: got ready=%b wr_en=%b, expected ready=1 wr_en=%b",
                 i, s_ready0, wr_en0, (i > 0));
      end
      s_valid = 1'b1;
      s_data  = 16'h0011 + 16'(i);
      a       = 32'd23 + 32'(i);
      q0.push_back({a, s_data});
      tick();
    end
    s_valid = 1'b0;
    n_checks++;
    if ({wr_en0, done0, busy0, s_ready0} !== 4'b1010) begin
      n_fail++;
      $display("FAIL basic_last_write: got wr_en/done/busy/ready=%b%b%b%b, expected 1010",
               wr_en0, done0, busy0, s_ready0);
    end
    tick();
    n_checks++;
    if ({wr_en0, done0} !== 2'b01) begin
      n_fail++;
      $display("FAIL basic_done: got wr_en=%b done=%b, expected wr_en=0 done=1", wr_en0, done0);
    end
    tick();
    n_checks++;
    if ({done0, busy0} !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_idle: got done=%b busy=%b, expected 0 0", done0, busy0);
    end
  endtask

  task automatic test_gap();
    logic exp_r;
    logic [31:0] a;
    base_addr = 32'd0; num_words = 32'd3; start2 = 1'b1;
    tick();
    start2  = 1'b0;
    s_valid = 1'b1;
    for (int c = 0; c < 9; c++) begin
      exp_r = (c == 0) || (c == 3) || (c == 6);
      n_checks++;
      if ({s_ready2, wr_en2, done2, busy2} !==
          {exp_r, (c == 1) || (c == 4) || (c == 7), (c == 8), (c <= 7)}) begin
        n_fail++;
        $display("FAIL gap_timing c%0d: got ready/wr_en/done/busy=%b%b%b%b, expected %b%b%b%b",
                 c, s_ready2, wr_en2, done2, busy2,
                 exp_r, (c == 1) || (c == 4) || (c == 7), (c == 8), (c <= 7));
      end
      s_data = 16'h00A0 + 16'(c);
      if (exp_r) begin
        a = 32'(c / 3);
        q2.push_back({a, s_data});
      end
      // A start (with a different base) in the middle of the load must be ignored
      start2    = (c == 2);
      base_addr = (c == 2) ? 32'd999 : 32'd0;
      tick();
    end
    s_valid = 1'b0; start2 = 1'b0;
  endtask

  task automatic test_zero();
    base_addr = 32'd5; num_words = 32'd0; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      n_checks++;
      if ({busy0, done0, s_ready0, wr_en0} !== {(c == 1), (c == 2), 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL zero_words c%0d: got busy/done/ready/wr_en=%b%b%b%b, expected %b%b00",
                 c, busy0, done0, s_ready0, wr_en0, (c == 1), (c == 2));
      end
      tick();
    end
  endtask

  task automatic test_toggle();
    logic [31:0] a;
    base_addr = 32'hFFFF_FFFD; num_words = 32'd8; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int c = 0; c <= 16; c++) begin
      n_checks++;
      if ({wr_en0, s_ready0, done0} !== {(c % 2 == 1) && (c <= 15), (c <= 14), (c == 16)}) begin
        n_fail++;
        $display("FAIL toggle c%0d: got wr_en/ready/done=%b%b%b, expected %b%b%b",
                 c, wr_en0, s_ready0, done0, (c % 2 == 1) && (c <= 15), (c <= 14), (c == 16));
      end
      s_valid = (c % 2 == 0) && (c <= 14);
      s_data  = 16'h0300 + 16'(c);
      if (s_valid) begin
        a = 32'hFFFF_FFFD + 32'(c / 2);
        q0.push_back({a, s_data});
      end
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic test_abort();
    logic [31:0] a;
    base_addr = 32'd200; num_words = 32'd6; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int c = 0; c <= 4; c++) begin
      n_checks++;
      if ({wr_en0, busy0, s_ready0, done0} !== {(c == 1) || (c == 2), (c <= 2), (c <= 2), 1'b0}) begin
        n_fail++;
        $display("FAIL abort c%0d: got wr_en/busy/ready/done=%b%b%b%b, expected %b%b%b0",
                 c, wr_en0, busy0, s_ready0, done0, (c == 1) || (c == 2), (c <= 2), (c <= 2));
      end
      s_valid = (c <= 2);
      abort   = (c == 2);
      s_data  = 16'h0400 + 16'(c);
      if (c <= 1) begin
        a = 32'd200 + 32'(c);
        q0.push_back({a, s_data});
      end
      tick();
    end
    s_valid = 1'b0; abort = 1'b0;
    base_addr = 32'd100; num_words = 32'd1; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    n_checks++;
    if (s_ready0 !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_ready: got %b, expected 1", s_ready0);
    end
    s_valid = 1'b1; s_data = 16'h005A;
    q0.push_back({32'd100, 16'h005A});
    tick();
    s_valid = 1'b0;
    n_checks++;
    if ({wr_en0, s_ready0} !== 2'b10) begin
      n_fail++;
      $display("FAIL restart_write: got wr_en=%b ready=%b, expected 1 0", wr_en0, s_ready0);
    end
    tick();
    n_checks++;
    if ({done0, wr_en0} !== 2'b10) begin
      n_fail++;
      $display("FAIL restart_done: got done=%b wr_en=%b, expected 1 0", done0, wr_en0);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    base_addr = 32'd10; num_words = 32'd5; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    s_valid = 1'b1; s_data = 16'h0077;
    tick();
    n_checks++;
    if ({wr_en2, busy2} !== 2'b11) begin
      n_fail++;
      $display("FAIL midreset_pre: got wr_en=%b busy=%b, expected 1 1", wr_en2, busy2);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({s_ready2, wr_en2, busy2, done2, wr_addr2, wr_data2} !== 52'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got ready/wr_en/busy/done=%b%b%b%b addr=%h data=%h, expected all 0",
               s_ready2, wr_en2, busy2, done2, wr_addr2, wr_data2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if ({s_ready2, wr_en2, busy2, done2} !== 4'b0000) begin
        n_fail++;
        $display("FAIL midreset_after c%0d: got ready/wr_en/busy/done=%b%b%b%b, expected 0000",
                 c, s_ready2, wr_en2, busy2, done2);
      end
    end
    s_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_zero();
    test_toggle();
    test_abort();
    test_reset_mid();
    tick();
    n_checks++;
    if ((q0.size() + q2.size()) !== 0) begin
      n_fail++;
      $display("FAIL missing_writes: got %0d writes outstanding, expected 0", q0.size() + q2.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_loader.md
WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16: width of weight words and of weight_wr_data.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32: width of base_addr, num_words and weight_wr_addr.
REQ-003 The block SHALL have parameter WR_GAP, default 0: idle cycles inserted after each issued write, for slow receivers.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all logic on rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: one-cycle load request, sampled in IDLE only.
REQ-007 The block SHALL have port base_addr, input, ADDR_WIDTH bits: address of the first word, captured on accepted start.
REQ-008 The block SHALL have port num_words, input, ADDR_WIDTH bits: number of words to load, captured on accepted start.
REQ-009 The block SHALL have port abort, input, 1 bit: synchronous cancel of a load in progress.
REQ-010 The block SHALL have port s_data, input, DATA_WIDTH bits: incoming weight word stream.
REQ-011 The block SHALL have port s_valid, input, 1 bit: s_data valid.
REQ-012 The block SHALL have port s_ready, output, 1 bit: the block accepts s_data this cycle.
REQ-013 The block SHALL have port weight_wr_data, output, DATA_WIDTH bits: write data to PE weight port.
REQ-014 The block SHALL have port weight_wr_addr, output, ADDR_WIDTH bits: write address to PE weight port.
REQ-015 The block SHALL have port weight_wr_en, output, 1 bit: one-cycle write strobe.
REQ-016 The block SHALL have port busy, output, 1 bit: high from accepted start until return to IDLE.
REQ-017 The block SHALL have port done, output, 1 bit: one-cycle pulse on load completion.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, GAP and FINISH.
REQ-019 In IDLE, start=1 SHALL capture base_addr and num_words, clear the word index, and move to LOAD, or to FINISH if num_words==0.
REQ-020 s_ready SHALL equal 1 only in LOAD; an accept is s_valid && s_ready.
REQ-021 On accept at index i, the next cycle SHALL show weight_wr_en=1, weight_wr_addr=base+i (modulo 2^ADDR_WIDTH) and weight_wr_data=s_data; latency is 1 cycle.
REQ-022 weight_wr_en SHALL be 0 on every cycle not directly following an accept; weight_wr_addr and weight_wr_data SHALL hold their last values.
REQ-023 After an accept that is not the last, the FSM SHALL stay in LOAD if WR_GAP==0, else go to GAP for exactly WR_GAP cycles and then return to LOAD.
REQ-024 The accept of index num_words-1 SHALL move the FSM to FINISH (the gap is skipped).
REQ-025 FINISH SHALL last one cycle, assert done=1, and return to IDLE; busy SHALL be 1 in LOAD, GAP and FINISH.
REQ-026 start outside IDLE SHALL be ignored.
REQ-027 abort=1 in LOAD or GAP SHALL return the FSM to IDLE next cycle with no done pulse.
REQ-028 A write already registered on the abort cycle SHALL still issue; an accept on the abort cycle SHALL be discarded.
REQ-029 abort takes priority over an accept in the same cycle; abort in IDLE or FINISH SHALL have no effect.
REQ-030 The internal word index SHALL be ADDR_WIDTH bits wide; the gap counter SHALL be $clog2(WR_GAP+1) bits wide, minimum 1.

Reset
REQ-031 rst_n=0 SHALL asynchronously force the FSM to IDLE and clear s_ready, weight_wr_en, busy, done, weight_wr_addr, weight_wr_data and all counters to 0.
REQ-032 Reset asserted mid-load SHALL abandon the load with no done pulse and no further writes.

Structure
REQ-033 State encodings and default DATA_WIDTH/ADDR_WIDTH constants SHALL live in the shared project package/header used by the PE blocks.
REQ-034 The block SHALL be one flat module with no sub-module.

Verification
REQ-035 The bench SHALL cover: base=23, num=4, WR_GAP=0, s_valid always 1, data 0x11..0x14 -> writes on 4 consecutive cycles at addresses 23..26 with that data, done 1 cycle after the last write, busy low next cycle.
REQ-036 The bench SHALL cover: WR_GAP=2, base=0, num=3 -> s_ready high 1 of every 3 cycles, writes spaced 3 cycles apart at addresses 0,1,2.
REQ-037 The bench SHALL cover: num=0 start -> done pulse on cycle 2 with zero writes and s_ready never high.
REQ-038 The bench SHALL cover: num=8 with s_valid toggling 1,0,1,0 -> exactly 8 writes at consecutive addresses, and no write after any cycle with s_valid=0.
REQ-039 The bench SHALL cover: abort after the 2nd accept of num=6 -> exactly 2 writes, no done, return to IDLE; then a new start base=100, num=1 -> single write at address 100.
REQ-040 The bench SHALL cover: rst_n pulled low mid-load -> all outputs 0 immediately, and after release s_ready stays 0 until the next start.
